// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StStale = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] PC_READ_OFS    = 32'd8;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, synchronous clear with priority over push/pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem request/ack, prefetch FIFO, write-back redirect.
// Optional FETCH_STATS_EN adds perf_fetched/perf_squashed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus8F,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;

    logic          fifo_push;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head;
    logic          pop;
    logic          issue;
    logic [31:0]   issue_addr;
    logic [31:0]   redirect_pc;
    logic          can_issue_idle;
    logic          can_issue_ack;
    logic [CW:0]   occ_ack;

    assign pop         = instr_valid & instr_ready;
    assign redirect_pc = word_align(ResultW);

    // Room check: entries held plus the word arriving now, less the one leaving.
    assign occ_ack        = {1'b0, fifo_count} + (CW + 1)'(1) - (CW + 1)'(pop);
    assign can_issue_ack  = (occ_ack < DEPTH_C);
    assign can_issue_idle = ~fifo_full | pop;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .clear (PCSrcW),
        .wdata ({addr_q, imem_rdata}),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        fifo_push  = 1'b0;
        issue      = 1'b0;
        issue_addr = pc_q;
        unique case (state_q)
            StIdle: begin
                if (PCSrcW) begin
                    issue      = 1'b1;
                    issue_addr = redirect_pc;
                end else if (can_issue_idle) begin
                    issue = 1'b1;
                end
            end
            StWait: begin
                if (imem_ack) begin
                    if (PCSrcW) begin
                        issue      = 1'b1;
                        issue_addr = redirect_pc;
                    end else begin
                        fifo_push = 1'b1;
                        if (can_issue_ack) begin
                            issue = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else if (PCSrcW) begin
                    // The bus request cannot be withdrawn; remember to drop its data.
                    state_d = StStale;
                    pc_d    = redirect_pc;
                end
            end
            StStale: begin
                if (imem_ack) begin
                    issue = 1'b1;
                    if (PCSrcW) begin
                        issue_addr = redirect_pc;
                    end
                end else if (PCSrcW) begin
                    pc_d = redirect_pc;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue) begin
            state_d = StWait;
            addr_d  = issue_addr;
            pc_d    = issue_addr + PC_INC;
        end
    end

    assign imem_req    = (state_q != StIdle);
    assign imem_addr   = addr_q;
    assign instr_valid = ~fifo_empty;
    assign InstrF      = fifo_head[31:0];
    assign PCPlus8F    = fifo_head[63:32] + PC_READ_OFS;

`ifdef FETCH_STATS_EN
    logic        discard;
    logic [31:0] fetched_q;
    logic [31:0] squashed_q;

    assign discard = imem_ack & ((state_q == StStale) | ((state_q == StWait) & PCSrcW));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q  <= '0;
            squashed_q <= '0;
        end else begin
            if (fifo_push) begin
                fetched_q <= fetched_q + 32'd1;
            end
            squashed_q <= squashed_q + 32'(discard) + (PCSrcW ? 32'(fifo_count) : 32'd0);
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed literal checks.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCPlus8F;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrcW;
    logic [31:0] ResultW;
`ifdef FETCH_STATS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
    logic [31:0] sq0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned mem_lat  = 0;
    bit          mem_hold = 1'b0;
    int unsigned wait_cnt = 0;
    bit          found;

    logic [31:0] exp_addr  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_instr [4] = '{32'hE000_0000, 32'hE000_0004, 32'hE000_0008, 32'hE000_000C};
    logic [31:0] exp_pc8   [4] = '{32'h8, 32'hC, 32'h10, 32'h14};

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .InstrF      (InstrF),
        .PCPlus8F    (PCPlus8F),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrcW      (PCSrcW),
        .ResultW     (ResultW)
`ifdef FETCH_STATS_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE000_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: acks after mem_lat wait cycles, never while mem_hold is set.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (imem_ack) wait_cnt = 0;
            if (imem_req && !mem_hold && wait_cnt >= mem_lat) begin
                imem_ack = 1'b1;
            end else begin
                imem_ack = 1'b0;
                if (imem_req) wait_cnt++;
            end
        end
    end

    // Reference model: one outstanding fetch, a queue of {addr,data}, the next PC.
    logic [63:0] mq [$];
    bit          m_out;
    bit          m_live;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    int unsigned m_fetched;
    int unsigned m_squashed;
    bit          m_pop;

    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            m_out      = 1'b0;
            m_live     = 1'b0;
            m_addr     = 32'h0;
            m_pc       = 32'h0;
            m_fetched  = 0;
            m_squashed = 0;
            check("rst_req", imem_req, 32'h0);
            check("rst_addr", imem_addr, 32'h0);
            check("rst_valid", instr_valid, 32'h0);
            check("rst_instr", InstrF, 32'h0);
            check("rst_pc8", PCPlus8F, 32'h8);
`ifdef FETCH_STATS_EN
            check("rst_fetched", perf_fetched, 32'h0);
            check("rst_squashed", perf_squashed, 32'h0);
`endif
        end else begin
            check("m_req", imem_req, m_out);
            check("m_addr", imem_addr, m_addr);
            check("m_valid", instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("m_instr", InstrF, mq[0][31:0]);
                check("m_pc8", PCPlus8F, mq[0][63:32] + 32'd8);
            end
`ifdef FETCH_STATS_EN
            check("m_fetched", perf_fetched, m_fetched);
            check("m_squashed", perf_squashed, m_squashed);
`endif
            m_pop = (mq.size() != 0) && instr_ready;
            if (PCSrcW) begin
                m_squashed += mq.size() + ((m_out && imem_ack) ? 1 : 0);
                mq.delete();
                m_tgt = {ResultW[31:2], 2'b00};
                if (!m_out || imem_ack) begin
                    m_out  = 1'b1;
                    m_live = 1'b1;
                    m_addr = m_tgt;
                    m_pc   = m_tgt + 32'd4;
                end else begin
                    m_live = 1'b0;
                    m_pc   = m_tgt;
                end
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_out && imem_ack) begin
                    if (m_live) begin
                        mq.push_back({m_addr, mem_word(m_addr)});
                        m_fetched++;
                    end else begin
                        m_squashed++;
                    end
                    m_out = 1'b0;
                end
                if (!m_out && mq.size() < DEPTH) begin
                    m_out  = 1'b1;
                    m_live = 1'b1;
                    m_addr = m_pc;
                    m_pc   = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive_at_edge(input logic src, input logic [31:0] tgt);
        @(posedge clk); #1;
        PCSrcW  = src;
        ResultW = tgt;
    endtask

    initial begin
        reset       = 1'b0;
        instr_ready = 1'b1;
        PCSrcW      = 1'b0;
        ResultW     = 32'h0;

        // Back-to-back fetch with zero-wait memory
        do_reset();
        @(negedge clk);
        check("t1_first_idle", imem_req, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_addr", imem_addr, exp_addr[i]);
            if (i >= 1) begin
                check("t1_instr", InstrF, exp_instr[i-1]);
                check("t1_pc8", PCPlus8F, exp_pc8[i-1]);
            end
        end

        // Decode stall fills the FIFO and stops requests
        instr_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        check("t2_req_dropped", imem_req, 32'h0);
        check("t2_valid", instr_valid, 32'h1);
        check("t2_head", InstrF, 32'hE000_0000);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(negedge clk);
        check("t2_head0", InstrF, 32'hE000_0000);
        check("t2_still_idle", imem_req, 32'h0);
        @(negedge clk);
        check("t2_head1", InstrF, 32'hE000_0004);
        check("t2_head1_pc8", PCPlus8F, 32'h0000_000C);
        check("t2_resume_addr", imem_addr, 32'h8);
        @(negedge clk);
        check("t2_head2", InstrF, 32'hE000_0008);

        // Three wait states
        mem_lat = 3;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_req_held", imem_req, 32'h1);
            check("t3_addr_held", imem_addr, 32'h0);
            check("t3_not_valid", instr_valid, 32'h0);
        end
        @(negedge clk);
        check("t3_valid", instr_valid, 32'h1);
        check("t3_instr", InstrF, 32'hE000_0000);
        check("t3_next_addr", imem_addr, 32'h4);
        mem_lat = 0;

        // Redirect while a request is unacked -> stale data dropped
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_addr == 32'hC && imem_ack) found = 1'b1;
        end
        check("t4_reach_c", found, 32'h1);
        mem_hold = 1'b1;
        drive_at_edge(1'b1, 32'h100);
        @(negedge clk);
        check("t4_addr_10", imem_addr, 32'h10);
        @(posedge clk); #1;
        PCSrcW   = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        check("t4_empty", instr_valid, 32'h0);
        check("t4_stale_req", imem_req, 32'h1);
        check("t4_stale_addr", imem_addr, 32'h10);
        @(negedge clk);
        check("t4_next_addr", imem_addr, 32'h100);
        check("t4_dropped", instr_valid, 32'h0);
        @(negedge clk);
        check("t4_head", InstrF, 32'hE000_0100);
        check("t4_head_pc8", PCPlus8F, 32'h108);

        // Redirect coinciding with ack and pop; unaligned target
        drive_at_edge(1'b1, 32'h203);
        @(negedge clk);
        check("t5_popping", instr_valid, 32'h1);
`ifdef FETCH_STATS_EN
        sq0 = perf_squashed;
`endif
        drive_at_edge(1'b0, 32'h0);
        @(negedge clk);
        check("t5_next_addr", imem_addr, 32'h200);
        check("t5_empty", instr_valid, 32'h0);
`ifdef FETCH_STATS_EN
        check("t5_squashed", perf_squashed, sq0 + 32'd2);
`endif

        // PC wrap
        drive_at_edge(1'b1, 32'hFFFF_FFFC);
        drive_at_edge(1'b0, 32'h0);
        @(negedge clk);
        check("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t6_wrap_addr", imem_addr, 32'h0);
        check("t6_wrap_instr", InstrF, 32'h1FFF_FFFC);
        check("t6_wrap_pc8", PCPlus8F, 32'h4);

        // Second redirect while stale, then reset in the middle of a stale request
        @(negedge clk);
        mem_hold = 1'b1;
        drive_at_edge(1'b1, 32'h300);
        drive_at_edge(1'b1, 32'h404);
        @(posedge clk); #1;
        PCSrcW   = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t7_second_target", imem_addr, 32'h404);
        mem_hold = 1'b1;
        drive_at_edge(1'b1, 32'h500);
        drive_at_edge(1'b0, 32'h0);
        mem_hold = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("t7_after_reset", imem_addr, 32'h0);
        check("t7_after_reset_req", imem_req, 32'h1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end feeding the pipelined controller and datapath decode register. Owns the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake. Buffers returned words in a small prefetch FIFO and presents them to Decode under a valid/ready handshake. A write-back-stage redirect (`PCSrcW`/`ResultW`) flushes the FIFO and squashes any in-flight fetch.

## Interface
- `DEPTH`, 2: prefetch FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held until acknowledged.
- `imem_addr`  out  32  word address of the request; stable while `imem_req`.
- `imem_ack`  in  1  request accepted and `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `InstrF`  out  32  FIFO head instruction.
- `PCPlus8F`  out  32  FIFO head address + 8 (ARM PC-read value).
- `instr_valid`  out  1  FIFO non-empty.
- `instr_ready`  in  1  Decode accepts head; low = stall.
- `PCSrcW`  in  1  redirect strobe from write-back.
- `ResultW`  in  32  redirect target.

## Operation
- State machine (`fetch_state_t`): IDLE (no outstanding request), WAIT (request outstanding, live), STALE (request outstanding, result to be discarded).
- Issue condition: `count + outstanding - pop < DEPTH`, where `pop = instr_valid & instr_ready`.
- IDLE → WAIT when the issue condition holds: `imem_req`=1, `imem_addr`=`pc_q`, `pc_q += 4`.
- WAIT, `imem_ack`=1: push `{imem_addr, imem_rdata}` into the FIFO.
  - If the issue condition still holds, issue the next address in the same edge and stay in WAIT.
  - Otherwise go to IDLE.
- WAIT, `imem_ack`=0: hold `imem_req` and `imem_addr` unchanged.
- Redirect (`PCSrcW`=1): `pc_q <= {ResultW[31:2],2'b00}` and the FIFO is cleared.
  - Same-cycle pop and push are ignored.
  - A request with `imem_ack`=0 that cycle moves to STALE. The request stays asserted because it cannot be withdrawn.
  - A request with `imem_ack`=1 that cycle has its data discarded; the next fetch comes from the new PC on the following cycle.
- STALE, `imem_ack`=1: discard the data, go to IDLE, or issue immediately from the redirected PC.
- STALE plus another `PCSrcW`: update `pc_q`, remain in STALE.
- Pop: advances the FIFO head. Push and pop in the same cycle keep `count` unchanged.
- `pc_q` wraps modulo 2^32. `PCPlus8F` is computed mod 2^32.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `InstrF`=0, `PCPlus8F`=8, `instr_valid`=0, `pc_q`=`RESET_PC`, FIFO empty, state IDLE.
- First request is asserted in the cycle after the first rising edge with reset released.
- With zero-wait memory (`imem_ack`=1 in the same cycle as `imem_req`): `instr_valid` rises one cycle after the ack.
- Steady-state throughput is 1 instruction/cycle.
- Redirect-to-new-request latency is 1 cycle (from IDLE, WAIT+ack, or STALE+ack).
- Outputs are registered or derived from the FIFO head. There is no combinational path from `imem_*` to `InstrF`/`instr_valid`.
- Reset asserted mid-transaction clears everything immediately, including STALE.
- The memory must tolerate an abandoned request when `reset` interrupts it.

## Configuration
- `FETCH_STATS_EN` defined:
  - Adds outputs `perf_fetched` (32) and `perf_squashed` (32), both reset to 0.
  - `perf_fetched` increments on each push.
  - `perf_squashed` increments on each discarded ack plus each FIFO entry cleared by a redirect (adds `count` that cycle).
- `FETCH_STATS_EN` undefined: ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Shared package `fetch_pkg`: `fetch_state_t` enum, `PC_INC`=4, `PC_READ_OFS`=8, default `RESET_PC`.
- Sub-module `fetch_fifo`:
  - Parameterized depth/width; async active-low reset.
  - Provides push, pop, synchronous clear, `count`, `empty`, `full`, head output.
  - Clear has priority over push/pop.

## Test plan
- Reset release, memory acks every cycle, `instr_ready`=1 → addresses 0,4,8,12 requested back-to-back; `InstrF` follows the same order one cycle later; `PCPlus8F` = 8,12,16,20.
- `instr_ready`=0 for 5 cycles with `DEPTH`=2 → exactly 2 entries buffered, `imem_req` drops to 0. Releasing the stall drains both entries, then fetch resumes at address 8.
- Memory acks after 3 wait cycles → `imem_req`/`imem_addr` stay stable throughout; `instr_valid` rises the cycle after the ack.
- Redirect to 0x100 while a request to 0x10 is unacked → STALE; the 0x10 data is dropped; the next request is 0x100; the FIFO is empty the cycle after the redirect.
- Redirect to 0x203 coinciding with an ack and a pop → the ack data is discarded and the next address is 0x200. With `FETCH_STATS_EN`, `perf_squashed` grows by `count`+1.
- `pc_q` = 0xFFFF_FFFC fetched → the next request address is 0x0000_0000 and `PCPlus8F` for the head is 0x0000_0004.
